// File: rtl/gate_op_pipe_if.sv
// rtl/gate_op_pipe_if.sv - operand-in / result-out handshake bundle for gate_op_pipe
interface gate_op_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_c;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_op;

  modport master (
    output in_valid, in_op, in_a, in_b, in_c, out_ready,
    input  in_ready, out_valid, out_data, out_op
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_c, out_ready,
    output in_ready, out_valid, out_data, out_op
  );
endinterface

// File: rtl/gate_op_pipe.sv
// rtl/gate_op_pipe.sv - two-stage bitwise AND/OR/BUF/NOT producer with saturating transfer counter
module gate_op_pipe #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gate_op_pipe_if.slave        bus,
  output logic [CNT_WIDTH-1:0] xfer_count
);

  logic             s1_valid;
  logic             s2_valid;
  logic             s1_en;
  logic             s2_en;
  logic [1:0]       s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [WIDTH-1:0] s1_c;
  logic [1:0]       s2_op;
  logic [WIDTH-1:0] s2_data;
  logic [WIDTH-1:0] result;

  // A stage may load when it is empty or its contents move on this cycle;
  // out_ready ripples combinationally back to in_ready for full throughput.
  assign s2_en        = !s2_valid || bus.out_ready;
  assign s1_en        = !s1_valid || s2_en;
  assign bus.in_ready = s1_en;

  assign bus.out_valid = s2_valid;
  assign bus.out_data  = s2_data;
  assign bus.out_op    = s2_op;

  always_comb begin
    result = '0;
    case (s1_op)
      2'd0:    result = s1_a & s1_b;
      2'd1:    result = s1_a | s1_b | s1_c;
      2'd2:    result = s1_a;
      default: result = ~s1_a;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_c     <= '0;
    end else if (s1_en) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_op <= bus.in_op;
        s1_a  <= bus.in_a;
        s1_b  <= bus.in_b;
        s1_c  <= bus.in_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_op    <= '0;
      s2_data  <= '0;
    end else if (s2_en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_op   <= s1_op;
        s2_data <= result;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_count <= '0;
    end else if (s2_valid && bus.out_ready && (xfer_count != {CNT_WIDTH{1'b1}})) begin
      xfer_count <= xfer_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_gate_op_pipe.sv
// tb/tb_gate_op_pipe.sv - scoreboard bench for gate_op_pipe with a saturation side instance
module tb_gate_op_pipe;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
  } stim_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
    int          acc_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] xcnt;
  logic [3:0]  xcnt4;

  gate_op_pipe_if #(.WIDTH(32)) bus ();
  gate_op_pipe_if #(.WIDTH(32)) bus4 ();

  gate_op_pipe #(.WIDTH(32), .CNT_WIDTH(16)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .xfer_count (xcnt)
  );

  gate_op_pipe #(.WIDTH(32), .CNT_WIDTH(4)) u_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus4),
    .xfer_count (xcnt4)
  );

  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc = 0;
  int    in_pct = 0;
  int    out_pct = 100;
  int    acc_cnt = 0;
  int    model_cnt = 0;
  int    sat_n = 0;
  bit    chk_lat = 1'b0;
  bit    stall = 1'b0;
  logic [1:0]  prev_op;
  logic [31:0] prev_data;
  stim_t stim_q[$];
  exp_t  sb_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] c);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b | c;
      2'd2:    return a;
      default: return ~a;
    endcase
  endfunction

  function automatic stim_t rnd_stim();
    stim_t s;
    s.op = 2'($urandom_range(3));
    s.a  = $urandom;
    s.b  = $urandom;
    s.c  = $urandom;
    return s;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Input driver: present head of stimulus queue or idle with junk data.
  initial begin
    bus.in_valid = 1'b0;
    bus.in_op = 2'd0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_c = '0;
    forever begin
      @(posedge clk);
      #1;
      if (stim_q.size() > 0 && $urandom_range(99) < in_pct) begin
        bus.in_valid = 1'b1;
        bus.in_op    = stim_q[0].op;
        bus.in_a     = stim_q[0].a;
        bus.in_b     = stim_q[0].b;
        bus.in_c     = stim_q[0].c;
      end else begin
        bus.in_valid = 1'b0;
        bus.in_op    = 2'($urandom_range(3));
        bus.in_a     = $urandom;
        bus.in_b     = $urandom;
        bus.in_c     = $urandom;
      end
    end
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = ($urandom_range(99) < out_pct);
    end
  end

  // Accept observer: each input handshake pushes its expected result.
  initial forever begin
    @(negedge clk);
    if (rst_n && bus.in_valid && bus.in_ready && stim_q.size() > 0) begin
      exp_t e;
      e.op      = stim_q[0].op;
      e.data    = ref_op(stim_q[0].op, stim_q[0].a, stim_q[0].b, stim_q[0].c);
      e.acc_cyc = cyc;
      sb_q.push_back(e);
      void'(stim_q.pop_front());
      acc_cnt++;
    end
  end

  // Output monitor: hold-stability, counter and in-order result checks.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        chk("hold_valid", 64'(bus.out_valid), 64'd1);
        chk("hold_data", {30'd0, bus.out_op, bus.out_data}, {30'd0, prev_op, prev_data});
      end
      chk("xfer_count", 64'(xcnt), 64'(model_cnt));
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_out: got %h with empty scoreboard (cycle %0d)", bus.out_data, cyc);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("out_data", 64'(bus.out_data), 64'(e.data));
          chk("out_op", 64'(bus.out_op), 64'(e.op));
          if (chk_lat) chk("latency", 64'(cyc - e.acc_cyc), 64'd2);
        end
        model_cnt++;
      end
      stall     = bus.out_valid && !bus.out_ready;
      prev_op   = bus.out_op;
      prev_data = bus.out_data;
    end
  end

  // Saturation instance: free-running stream, counter must clamp at 15.
  initial begin
    bus4.in_valid  = 1'b1;
    bus4.in_op     = 2'd3;
    bus4.in_a      = 32'h1234_5678;
    bus4.in_b      = '0;
    bus4.in_c      = '0;
    bus4.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sat_n = 0;
      end else begin
        chk("sat_count", 64'(xcnt4), 64'((sat_n > 15) ? 15 : sat_n));
        if (bus4.out_valid && bus4.out_ready) sat_n++;
      end
    end
  end

  task automatic drain(input int budget);
    int n = 0;
    while ((stim_q.size() != 0 || sb_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("drain_in_time", 64'(n < budget), 64'd1);
  endtask

  task automatic push_s(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] c);
    stim_t s;
    s.op = op;
    s.a  = a;
    s.b  = b;
    s.c  = c;
    stim_q.push_back(s);
  endtask

  initial begin
    int acc0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_out_op", 64'(bus.out_op), 64'd0);
    chk("rst_xcnt", 64'(xcnt), 64'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Single AND, then back-to-back mixed ops, out_ready held high.
    chk_lat = 1'b1;
    in_pct  = 100;
    push_s(2'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0);
    drain(50);
    push_s(2'd3, 32'h0, 32'h1111_1111, 32'h2222_2222);
    push_s(2'd1, 32'h1, 32'h2, 32'h4);
    push_s(2'd2, 32'hDEAD_BEEF, 32'h5555_5555, 32'hAAAA_AAAA);
    push_s(2'd0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF);
    acc0 = acc_cnt;
    repeat (4) @(negedge clk);
    chk("b2b_accepts", 64'(acc_cnt - acc0), 64'd4);
    drain(50);
    chk_lat = 1'b0;

    // Stalled output with continuous input: only two items fit.
    out_pct = 0;
    @(posedge clk);
    #2;
    for (int i = 0; i < 6; i++) stim_q.push_back(rnd_stim());
    acc0 = acc_cnt;
    repeat (6) @(negedge clk);
    chk("full_accepts", 64'(acc_cnt - acc0), 64'd2);
    chk("full_in_ready", 64'(bus.in_ready), 64'd0);
    chk("full_out_valid", 64'(bus.out_valid), 64'd1);
    out_pct = 100;
    drain(100);
    chk("full_all_out", 64'(acc_cnt - acc0), 64'd6);

    // Mid-run reset with traffic in flight.
    in_pct  = 70;
    out_pct = 50;
    for (int i = 0; i < 50; i++) stim_q.push_back(rnd_stim());
    repeat (20) @(posedge clk);
    #3;
    in_pct = 0;
    rst_n  = 1'b0;
    bus.in_valid = 1'b0;
    stim_q.delete();
    sb_q.delete();
    model_cnt = 0;
    #1;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_xcnt", 64'(xcnt), 64'd0);
    chk("midrst_xcnt4", 64'(xcnt4), 64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    out_pct = 100;
    @(negedge clk);
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    repeat (3) @(negedge clk);
    chk("midrst_no_stale", 64'(bus.out_valid), 64'd0);

    // Long random run.
    in_pct  = 70;
    out_pct = 60;
    for (int i = 0; i < 1000; i++) stim_q.push_back(rnd_stim());
    drain(20000);
    chk("final_count", 64'(xcnt), 64'(model_cnt));
    chk("sat_enough", 64'(sat_n >= 20), 64'd1);
    chk("sat_final", 64'(xcnt4), 64'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
